// File: rtl/serial_out_pkg.sv
// Shared state encoding, mode constants and period lookup for the multi-rate serial output channel.
package serial_out_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_ONE_SHOT = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_REPEAT_N = 2'd2;

    // Widest select / entry that period_of() can handle; instances must stay within these.
    localparam int SEL_W_MAX = 4;
    localparam int CNT_W_MAX = 16;
    localparam int TBL_W_MAX = (2**SEL_W_MAX) * CNT_W_MAX;

    function automatic logic [CNT_W_MAX-1:0] period_of(
        input logic [TBL_W_MAX-1:0] tbl,
        input logic [SEL_W_MAX-1:0] sel,
        input int unsigned          cnt_w
    );
        logic [CNT_W_MAX-1:0] mask;
        logic [CNT_W_MAX-1:0] entry;
        mask  = ~({CNT_W_MAX{1'b1}} << cnt_w);
        entry = CNT_W_MAX'(tbl >> (32'(sel) * cnt_w)) & mask;
        return (entry == '0) ? CNT_W_MAX'(1) : entry;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..period-1 after each load and flags the last clk of the bit.
module serial_bit_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    output logic             last,
    output logic             last_next
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] count_inc;
    logic             running;

    assign count_inc = count + CNT_W'(1);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        last_next = 1'b0;
        if (clear) begin
            last_next = 1'b0;
        end else if (load) begin
            last_next = (period == CNT_W'(1));
        end else if (running) begin
            last_next = (count_inc == period_q - CNT_W'(1));
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            period_q <= '0;
            running  <= 1'b0;
            last     <= 1'b0;
        end else begin
            last <= last_next;
            if (clear) begin
                count    <= '0;
                period_q <= '0;
                running  <= 1'b0;
            end else if (load) begin
                count    <= '0;
                period_q <= period;
                running  <= 1'b1;
            end else if (running) begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: rtl/multi_freq_serial_out.sv
// Multi-rate serial pattern output: LSB-first, per-bit period from a runtime table; one-shot/repeat/repeat-N.
// Define SERIAL_OUT_SHADOW_EN to source every capture from i_load-updated shadow registers.
module multi_freq_serial_out
    import serial_out_pkg::*;
#(
    parameter int DATA_BIT   = 32,
    parameter int FREQ_SEL_W = 2,
    parameter int CNT_W      = 8,
    parameter int REP_W      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_start,
    input  logic                              i_stop,
    input  logic [1:0]                        i_mode,
    input  logic [REP_W-1:0]                  i_repeat_num,
    input  logic [DATA_BIT-1:0]               i_output_pattern,
    input  logic [DATA_BIT*FREQ_SEL_W-1:0]    i_freq_pattern,
    input  logic [(2**FREQ_SEL_W)*CNT_W-1:0]  i_period_table,
    input  logic                              i_load,
    output logic                              o_serial_out,
    output logic                              o_bit_tick,
    output logic                              o_done_tick,
    output logic                              o_busy,
    output logic [5:0]                        o_bit_idx
);

    localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam int FRQ_W = DATA_BIT * FREQ_SEL_W;
    localparam int TBL_W = (2**FREQ_SEL_W) * CNT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);

    state_t              state;
    logic [DATA_BIT-1:0] data_buf;
    logic [FRQ_W-1:0]    freq_buf;
    logic [TBL_W-1:0]    tbl_buf;
    logic [IDX_W-1:0]    bit_idx;
    logic [REP_W-1:0]    passes_left;

    logic [DATA_BIT-1:0] src_pattern;
    logic [FRQ_W-1:0]    src_freq;
    logic [TBL_W-1:0]    src_tbl;

`ifdef SERIAL_OUT_SHADOW_EN
    logic [DATA_BIT-1:0] shadow_pattern;
    logic [FRQ_W-1:0]    shadow_freq;
    logic [TBL_W-1:0]    shadow_tbl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_pattern <= '0;
            shadow_freq    <= '0;
            shadow_tbl     <= '0;
        end else if (i_load) begin
            shadow_pattern <= i_output_pattern;
            shadow_freq    <= i_freq_pattern;
            shadow_tbl     <= i_period_table;
        end
    end

    // Write-through: a load on a capture edge is seen by that capture.
    assign src_pattern = i_load ? i_output_pattern : shadow_pattern;
    assign src_freq    = i_load ? i_freq_pattern   : shadow_freq;
    assign src_tbl     = i_load ? i_period_table   : shadow_tbl;
`else
    logic unused_load;
    assign unused_load = i_load;
    assign src_pattern = i_output_pattern;
    assign src_freq    = i_freq_pattern;
    assign src_tbl     = i_period_table;
`endif

    logic                  bit_last;
    logic                  last_next;
    logic                  at_last_bit;
    logic                  pass_end;
    logic                  restart;
    logic                  start_ok;
    logic                  capture;
    logic                  advance;
    logic                  finish;
    logic                  timer_clear;
    logic                  timer_load;
    logic [IDX_W-1:0]      idx_inc;
    logic [IDX_W-1:0]      idx_next;
    logic [FREQ_SEL_W-1:0] sel_next;
    logic [CNT_W-1:0]      period_next;

    assign idx_inc = bit_idx + IDX_W'(1);

    always_comb begin
        at_last_bit = (bit_idx == LAST_IDX);
        pass_end    = (state == S_RUN) && bit_last && at_last_bit;
        restart     = pass_end && ((i_mode == MODE_REPEAT) ||
                                   ((i_mode == MODE_REPEAT_N) && (passes_left > REP_W'(1))));
        start_ok    = (state == S_IDLE) && i_start;
        capture     = !i_stop && (start_ok || restart);
        advance     = !i_stop && (state == S_RUN) && bit_last && !at_last_bit;
        finish      = pass_end && !restart;
        timer_clear = i_stop || finish;
        timer_load  = capture || advance;

        sel_next = capture ? src_freq[FREQ_SEL_W-1:0]
                           : FREQ_SEL_W'(freq_buf >> (32'(idx_inc) * FREQ_SEL_W));
        period_next = CNT_W'(period_of(TBL_W_MAX'(capture ? src_tbl : tbl_buf),
                                       SEL_W_MAX'(sel_next), CNT_W));

        idx_next = bit_idx;
        if (i_stop || finish || capture) begin
            idx_next = '0;
        end else if (advance) begin
            idx_next = idx_inc;
        end
    end

    serial_bit_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .load      (timer_load),
        .period    (period_next),
        .last      (bit_last),
        .last_next (last_next)
    );

    // NOTE: the capture buffers sit in the reset branch as well, so a reset leaves no stale pattern behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            data_buf     <= '0;
            freq_buf     <= '0;
            tbl_buf      <= '0;
            bit_idx      <= '0;
            passes_left  <= '0;
            o_serial_out <= 1'b0;
            o_done_tick  <= 1'b0;
        end else begin
            bit_idx     <= idx_next;
            o_done_tick <= last_next && (idx_next == LAST_IDX);
            if (i_stop) begin
                state        <= S_IDLE;
                o_serial_out <= 1'b0;
            end else if (capture) begin
                state        <= S_RUN;
                data_buf     <= src_pattern;
                freq_buf     <= src_freq;
                tbl_buf      <= src_tbl;
                o_serial_out <= src_pattern[0];
                if (start_ok) begin
                    passes_left <= i_repeat_num;
                end else if (i_mode == MODE_REPEAT_N) begin
                    passes_left <= passes_left - REP_W'(1);
                end
            end else if (advance) begin
                o_serial_out <= data_buf[idx_inc];
            end else if (finish) begin
                state        <= S_IDLE;
                o_serial_out <= 1'b0;
            end
        end
    end

    assign o_bit_tick = bit_last;
    assign o_busy     = (state == S_RUN);
    assign o_bit_idx  = 6'(bit_idx);

endmodule

// File: tb/tb_multi_freq_serial_out.sv
// Scoreboard bench for multi_freq_serial_out: a pass-level model queues expected bits, a monitor checks each bit tick.
`timescale 1ns/1ps
module tb_multi_freq_serial_out;
    import serial_out_pkg::*;

    localparam int DATA_BIT   = 32;
    localparam int FREQ_SEL_W = 2;
    localparam int CNT_W      = 8;
    localparam int REP_W      = 8;

    logic                             clk = 1'b0;
    logic                             rst = 1'b1;
    logic                             i_start = 1'b0;
    logic                             i_stop = 1'b0;
    logic [1:0]                       i_mode = '0;
    logic [REP_W-1:0]                 i_repeat_num = '0;
    logic [DATA_BIT-1:0]              i_output_pattern = '0;
    logic [DATA_BIT*FREQ_SEL_W-1:0]   i_freq_pattern = '0;
    logic [(2**FREQ_SEL_W)*CNT_W-1:0] i_period_table = '0;
    logic                             i_load = 1'b0;
    logic                             o_serial_out;
    logic                             o_bit_tick;
    logic                             o_done_tick;
    logic                             o_busy;
    logic [5:0]                       o_bit_idx;

    always #5 clk = ~clk;

    multi_freq_serial_out #(
        .DATA_BIT(DATA_BIT), .FREQ_SEL_W(FREQ_SEL_W), .CNT_W(CNT_W), .REP_W(REP_W)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
        .i_repeat_num(i_repeat_num), .i_output_pattern(i_output_pattern),
        .i_freq_pattern(i_freq_pattern), .i_period_table(i_period_table), .i_load(i_load),
        .o_serial_out(o_serial_out), .o_bit_tick(o_bit_tick), .o_done_tick(o_done_tick),
        .o_busy(o_busy), .o_bit_idx(o_bit_idx)
    );

    typedef struct {
        logic val;
        int   idx;
        logic done;
        int   len;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   len_cnt  = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bit k of a pass lasts max(1, table entry picked by the k-th select) clocks.
    function automatic int model_period(logic [63:0] freq, logic [31:0] tbl, int k);
        int sel;
        int entry;
        sel   = int'((freq >> (2 * k)) & 64'h3);
        entry = int'((tbl >> (8 * sel)) & 32'hFF);
        return (entry == 0) ? 1 : entry;
    endfunction

    task automatic push_pass(logic [31:0] pat, logic [63:0] freq, logic [31:0] tbl);
        for (int k = 0; k < DATA_BIT; k++) begin
            exp_t e;
            e.val  = pat[k];
            e.idx  = k;
            e.done = (k == DATA_BIT - 1);
            e.len  = model_period(freq, tbl, k);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: counts busy clocks per bit and compares each bit tick against the queue head.
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            len_cnt = 0;
        end else begin
            if (o_busy) begin
                len_cnt++;
            end else begin
                len_cnt = 0;
                check("idle_quiet", {o_serial_out, o_bit_tick, o_done_tick}, 3'b000);
            end
            if (o_done_tick) check("done_implies_bit_tick", o_bit_tick, 1);
            if (o_bit_tick && o_busy) begin
                check("tick_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("bit_value", o_serial_out, e.val);
                    check("bit_index", o_bit_idx, e.idx);
                    check("done_tick", o_done_tick, e.done);
                    check("bit_length", len_cnt, e.len);
                    if (o_done_tick) done_cnt++;
                end
                len_cnt = 0;
            end
        end
    end

    task automatic set_src(logic [31:0] pat, logic [63:0] freq, logic [31:0] tbl);
        @(posedge clk); #1;
        i_output_pattern = pat;
        i_freq_pattern   = freq;
        i_period_table   = tbl;
        i_load           = 1'b1;
        @(posedge clk); #1;
        i_load = 1'b0;
    endtask

    task automatic start_run(logic [1:0] mode, logic [7:0] n, logic first_bit);
        @(posedge clk); #1;
        i_mode       = mode;
        i_repeat_num = n;
        i_start      = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        check("start_busy", o_busy, 1);
        check("start_bit0", o_serial_out, first_bit);
        check("start_idx0", o_bit_idx, 0);
    endtask

    task automatic wait_idle(int budget);
        for (int i = 0; i < budget && o_busy; i++) @(negedge clk);
        check("reach_idle", o_busy, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_idx(int idx);
        for (int i = 0; i < 2000 && o_bit_idx != 6'(idx); i++) @(negedge clk);
        check("reach_bit_idx", o_bit_idx, idx);
    endtask

    function automatic logic [31:0] rand_tbl();
        return {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pat, pat_b, tbl;
        logic [63:0] freq, freq_b;
        int          cyc, d0, cnt, npass;
        logic [1:0]  mode;
        logic [7:0]  n;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_serial_out, o_bit_tick, o_done_tick, o_busy, o_bit_idx}, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Asynchronous reset in the middle of a repeating run.
        pat = $urandom(); freq = {$urandom(), $urandom()}; tbl = rand_tbl();
        set_src(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        start_run(MODE_REPEAT, 8'd0, pat[0]);
        repeat (20) @(negedge clk);
        check("busy_before_reset", o_busy, 1);
        mon_en = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {o_serial_out, o_bit_tick, o_done_tick, o_busy, o_bit_idx}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {o_busy, o_serial_out}, 0);
        mon_en = 1'b1;

        // One-shot, every bit 3 clocks: done tick on clock 96.
        pat = 32'hA5A5_0F0F; freq = 64'h5555_5555_5555_5555; tbl = 32'h0102_0304;
        set_src(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        start_run(MODE_ONE_SHOT, 8'd0, pat[0]);
        cyc = 1;
        while (!o_done_tick && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("oneshot_done_clk", cyc, 96);
        wait_idle(10);

        // Mixed rates: select k%4 on table {1,2,0,5}.
        pat = $urandom(); tbl = 32'h0500_0201;
        freq = '0;
        for (int k = 0; k < DATA_BIT; k++) freq[2*k +: 2] = 2'(k % 4);
        set_src(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        start_run(MODE_ONE_SHOT, 8'd0, pat[0]);
        wait_idle(300);

        // Repeat N = 3, then N = 0 meaning a single pass.
        pat = $urandom(); freq = {$urandom(), $urandom()}; tbl = rand_tbl();
        set_src(pat, freq, tbl);
        for (int p = 0; p < 3; p++) push_pass(pat, freq, tbl);
        d0 = done_cnt;
        start_run(MODE_REPEAT_N, 8'd3, pat[0]);
        wait_idle(3000);
        check("repeat3_done_ticks", done_cnt - d0, 3);
        push_pass(pat, freq, tbl);
        d0 = done_cnt;
        start_run(MODE_REPEAT_N, 8'd0, pat[0]);
        wait_idle(1000);
        check("repeat0_done_ticks", done_cnt - d0, 1);

        // Start while busy is ignored, even with different pattern on the port.
        pat = $urandom(); freq = {$urandom(), $urandom()}; tbl = rand_tbl();
        set_src(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        start_run(MODE_ONE_SHOT, 8'd0, pat[0]);
        wait_idx(3);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_output_pattern = ~pat;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_output_pattern = pat;
        wait_idle(1000);
        repeat (3) @(negedge clk);
        check("ignored_start_stays_idle", o_busy, 0);

        // Stop at bit 7 together with a start: idle next clock, start lost.
        pat = $urandom(); freq = {$urandom(), $urandom()}; tbl = rand_tbl();
        set_src(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        start_run(MODE_REPEAT, 8'd0, pat[0]);
        wait_idx(7);
        i_stop  = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_stop  = 1'b0;
        i_start = 1'b0;
        @(negedge clk);
        check("stop_bit7_idle", {o_busy, o_serial_out, o_bit_tick, o_done_tick}, 0);
        repeat (2) @(negedge clk);
        check("stop_beats_start", o_busy, 0);
        exp_q.delete();

        // Stop on the last clock of a pass in repeat mode: no restart.
        pat = $urandom(); freq = {$urandom(), $urandom()}; tbl = rand_tbl();
        set_src(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        start_run(MODE_REPEAT, 8'd0, pat[0]);
        for (int i = 0; i < 1000 && !o_done_tick; i++) @(negedge clk);
        check("reach_pass_end", o_done_tick, 1);
        i_stop = 1'b1;
        @(posedge clk); #1;
        i_stop = 1'b0;
        @(negedge clk);
        check("stop_pass_end_idle", {o_busy, o_serial_out, o_bit_tick, o_done_tick}, 0);
        check("stop_pass_end_left", exp_q.size(), DATA_BIT);
        exp_q.delete();

        // New sources mid-pass take effect at the next restart; mode change at the next boundary.
        pat = $urandom(); freq = {$urandom(), $urandom()}; tbl = rand_tbl();
        pat_b = $urandom(); freq_b = {$urandom(), $urandom()};
        set_src(pat, freq, tbl);
        push_pass(pat, freq, tbl);
        push_pass(pat_b, freq_b, tbl);
        push_pass(pat_b, freq_b, tbl);
        d0 = done_cnt;
        start_run(MODE_REPEAT, 8'd0, pat[0]);
        wait_idx(10);
        set_src(pat_b, freq_b, tbl);
        cnt = 0;
        for (int i = 0; i < 3000 && cnt < 2; i++) begin
            @(negedge clk);
            if (o_done_tick) cnt++;
        end
        @(posedge clk); #1;
        i_mode = MODE_ONE_SHOT;
        wait_idle(1000);
        check("switch_done_ticks", done_cnt - d0, 3);

        // Randomised one-shot / repeat-N runs.
        for (int r = 0; r < 6; r++) begin
            pat = $urandom(); freq = {$urandom(), $urandom()}; tbl = rand_tbl();
            case ($urandom_range(0, 2))
                0:       mode = MODE_ONE_SHOT;
                1:       mode = MODE_REPEAT_N;
                default: mode = 2'd3;
            endcase
            n = 8'($urandom_range(0, 3));
            npass = (mode == MODE_REPEAT_N && n > 0) ? int'(n) : 1;
            set_src(pat, freq, tbl);
            for (int p = 0; p < npass; p++) push_pass(pat, freq, tbl);
            d0 = done_cnt;
            start_run(mode, n, pat[0]);
            wait_idle(3000);
            check("random_done_ticks", done_cnt - d0, npass);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
